psg_ecfs_lvdcdc_sd_adc_offset_cal: RTL and testbench
====================================================

Name: psg_ecfs_lvdcdc_sd_adc_offset_cal

Overview:
Offset calibration sequencer for the three-channel sinc3 sigma-delta ADC in the autonomous DCDC converter (phase A current, phase B current, output voltage). It drives the three 16-bit offset inputs of the ADC datapath.
- On command, it forces the offsets to zero, discards the filter-settling samples, averages 2^AVG_LOG2 raw 16-bit samples per channel, range-checks the results and loads them as the new offsets.
- Outside calibration, firmware can write the offsets directly.

Parameters:
- AVG_LOG2, 6, log2 of the number of samples averaged per channel (legal range 1..8).
- SETTLE_SAMPLES, 4, number of sample_valid strobes discarded after the offsets are forced to zero (legal range 1..15).
- TIMEOUT_CYCLES, 1024, maximum number of clk_adc cycles between sample_valid strobes while calibrating.
- MAX_OFFSET, 16'd2048, largest accepted absolute value of a computed offset.

Ports:
- clk_adc  in  1  ADC clock; the only clock.
- reset  in  1  Synchronous reset, active-high.
- cal_start  in  1  One-cycle request to start calibration; ignored unless in IDLE.
- cal_abort  in  1  Abort request; returns to IDLE and restores the previous offsets.
- wr_en  in  1  Manual offset write strobe; honoured only in IDLE.
- wr_sel  in  2  Write target: 0 = phase A, 1 = phase B, 2 = voltage; 3 is ignored.
- wr_data  in  16  Manual offset value.
- sample_valid  in  1  One-cycle strobe from the ADC datapath.
- sample_i_phase_a_16  in  16  Signed raw phase A sample, qualified by sample_valid.
- sample_i_phase_b_16  in  16  Signed raw phase B sample.
- sample_v_out_16  in  16  Signed raw voltage sample.
- offset_i_phase_a  out  16  Offset to the datapath.
- offset_i_phase_b  out  16  Offset to the datapath.
- offset_v  out  16  Offset to the datapath.
- busy  out  1  High in every state except IDLE.
- cal_done  out  1  One-cycle pulse on successful completion.
- cal_error  out  1  Sticky failure flag; cleared by the next accepted cal_start.
- err_code  out  2  Failure reason: 0 = none, 1 = timeout, 2 = range, 3 = abort.

Behaviour:
- Reset: all offsets 0, busy 0, cal_done 0, cal_error 0, err_code 0, state IDLE, accumulators and counters 0.
- Internal saved_* registers hold the committed offsets. The outputs show saved_* in IDLE and 0 in every other state.

State machine:
- IDLE
  - cal_start -> SETTLE. Clear the accumulators, counters, cal_error and err_code. busy rises the next cycle.
  - wr_en with wr_sel 0..2 -> the selected saved_* register takes wr_data; visible on the output the next cycle.
  - cal_start and wr_en in the same cycle: the write is dropped.
- SETTLE
  - Count sample_valid strobes.
  - After SETTLE_SAMPLES strobes -> ACCUM. The strobe that completes the count is not accumulated.
- ACCUM
  - On each sample_valid, add each sign-extended sample into its own (16+AVG_LOG2)-bit signed accumulator.
  - After 2^AVG_LOG2 strobes -> APPLY.
- APPLY (exactly 1 cycle)
  - avg = accumulator arithmetic-shifted right by AVG_LOG2, truncated toward minus infinity.
  - If any |avg| > MAX_OFFSET: raise cal_error with err_code 2, leave saved_* unchanged, go to IDLE.
  - Otherwise load all three saved_* registers together, pulse cal_done for 1 cycle, go to IDLE.
  - Offsets are never partially updated.
- Timeout
  - In SETTLE or ACCUM, a cycle counter restarts on each sample_valid.
  - When it reaches TIMEOUT_CYCLES: cal_error with err_code 1, go to IDLE, saved_* unchanged.
- Abort
  - cal_abort in any non-IDLE state: cal_error with err_code 3, go to IDLE next cycle, saved_* unchanged.
  - cal_abort has priority over sample_valid and timeout in the same cycle.
  - cal_abort in IDLE has no effect.
- Latency: cal_start to zeroed offsets is 1 cycle. APPLY to updated offsets and cal_done is 1 cycle. Both the outputs and cal_done become valid in the same cycle.
- cal_start while busy: ignored.
- reset mid-calibration: returns to the reset values. Previously calibrated offsets are lost.

Optional Feature:
- Macro PSG_ECFS_SD_ADC_CAL_ROUND_EN.
- Defined: APPLY adds 2^(AVG_LOG2-1) to each accumulator before the shift (round half up). The range check uses the rounded value.
- Undefined: plain truncating arithmetic shift, as described under Behaviour.

Test Plan:
1. Reset, then wr_en with wr_sel=1 and wr_data=16'h0123 in IDLE -> offset_i_phase_b=16'h0123 the next cycle; the other offsets stay 0.
2. cal_start with constant samples A=100, B=-37, V=512, and sample_valid every 128 cycles -> offsets 0 while busy. cal_done arrives after 4+64 strobes, then offsets are 100 / 16'hFFDB / 512 and busy is 0.
3. Phase A samples alternating 3 and 4 over 64 strobes -> offset_i_phase_a=3 with the macro undefined, 4 with PSG_ECFS_SD_ADC_CAL_ROUND_EN.
4. Prior offsets 10/20/30, then calibrate with V samples constant at 3000 -> cal_error=1, err_code=2, offsets back to 10/20/30, no cal_done.
5. sample_valid stops after the 10th strobe -> after TIMEOUT_CYCLES, err_code=1 and prior offsets restored. A following cal_start clears cal_error.
6. cal_abort asserted in the same cycle as the final ACCUM sample_valid -> err_code=3, no cal_done, offsets unchanged. cal_start pulsed while busy has no effect.

Source files
------------

// File: rtl/psg_ecfs_lvdcdc_sd_adc_offset_cal_if.sv
// Control, sample and offset bundle between firmware/ADC datapath and the offset calibration sequencer.
// The slave side is the sequencer, and the master side is its environment.
interface psg_ecfs_lvdcdc_sd_adc_offset_cal_if;
   logic               cal_start;
   logic               cal_abort;
   logic               wr_en;
   logic [1:0]         wr_sel;
   logic [15:0]        wr_data;
   logic               sample_valid;
   logic signed [15:0] sample_i_phase_a_16;
   logic signed [15:0] sample_i_phase_b_16;
   logic signed [15:0] sample_v_out_16;
   logic signed [15:0] offset_i_phase_a;
   logic signed [15:0] offset_i_phase_b;
   logic signed [15:0] offset_v;
   logic               busy;
   logic               cal_done;
   logic               cal_error;
   logic [1:0]         err_code;

   modport master (
      output cal_start, cal_abort, wr_en, wr_sel, wr_data, sample_valid,
             sample_i_phase_a_16, sample_i_phase_b_16, sample_v_out_16,
      input  offset_i_phase_a, offset_i_phase_b, offset_v,
             busy, cal_done, cal_error, err_code
   );

   modport slave (
      input  cal_start, cal_abort, wr_en, wr_sel, wr_data, sample_valid,
             sample_i_phase_a_16, sample_i_phase_b_16, sample_v_out_16,
      output offset_i_phase_a, offset_i_phase_b, offset_v,
             busy, cal_done, cal_error, err_code
   );
endinterface

// File: rtl/psg_ecfs_lvdcdc_sd_adc_offset_cal.sv
// Offset calibration sequencer for the three-channel sinc3 SD-ADC (phase A/B current, output voltage).
// Optional macro PSG_ECFS_SD_ADC_CAL_ROUND_EN: round half up when averaging instead of truncating.
module psg_ecfs_lvdcdc_sd_adc_offset_cal #(
   parameter int          AVG_LOG2       = 6,
   parameter int          SETTLE_SAMPLES = 4,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [15:0] MAX_OFFSET     = 16'd2048
) (
   input  logic clk_adc,
   input  logic reset,
   psg_ecfs_lvdcdc_sd_adc_offset_cal_if.slave bus
);
   localparam int ACC_W = 16 + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 + 1 > 4) ? AVG_LOG2 + 1 : 4;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
   localparam logic [CNT_W-1:0]    ACCUM_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic signed [16:0]  MAX_POS     = $signed({1'b0, MAX_OFFSET});
   localparam logic signed [16:0]  MAX_NEG     = -MAX_POS;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_RANGE   = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, APPLY} state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc_a, acc_b, acc_v;
   logic [CNT_W-1:0]        smp_cnt;
   logic [TMO_W-1:0]        tmo_cnt;
   logic signed [15:0]      saved_a, saved_b, saved_v;

   logic signed [16:0]      avg_a, avg_b, avg_v;
   logic                    fail;
   logic [1:0]              fail_code;

`ifdef PSG_ECFS_SD_ADC_CAL_ROUND_EN
   localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (AVG_LOG2 - 1);
`endif

   // Average with one guard bit so the rounding increment cannot wrap the accumulator.
   function automatic logic signed [16:0] avg_of(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W:0] ext;
      ext = {acc[ACC_W-1], acc};
`ifdef PSG_ECFS_SD_ADC_CAL_ROUND_EN
      ext = ext + RND_HALF;
`endif
      return 17'(ext >>> AVG_LOG2);
   endfunction

   function automatic logic in_range(input logic signed [16:0] v);
      return (v <= MAX_POS) && (v >= MAX_NEG);
   endfunction

   always_comb begin
      avg_a     = avg_of(acc_a);
      avg_b     = avg_of(acc_b);
      avg_v     = avg_of(acc_v);
      fail      = 1'b0;
      fail_code = ERR_NONE;
      // Abort outranks a same-cycle strobe or timeout.
      if (state != IDLE) begin
         if (bus.cal_abort) begin
            fail      = 1'b1;
            fail_code = ERR_ABORT;
         end else if (state == APPLY) begin
            if (!(in_range(avg_a) && in_range(avg_b) && in_range(avg_v))) begin
               fail      = 1'b1;
               fail_code = ERR_RANGE;
            end
         end else if (!bus.sample_valid && tmo_cnt == TMO_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk_adc) begin
      if (reset) begin
         state                <= IDLE;
         acc_a                <= '0;
         acc_b                <= '0;
         acc_v                <= '0;
         smp_cnt              <= '0;
         tmo_cnt              <= '0;
         saved_a              <= '0;
         saved_b              <= '0;
         saved_v              <= '0;
         bus.offset_i_phase_a <= '0;
         bus.offset_i_phase_b <= '0;
         bus.offset_v         <= '0;
         bus.busy             <= 1'b0;
         bus.cal_done         <= 1'b0;
         bus.cal_error        <= 1'b0;
         bus.err_code         <= ERR_NONE;
      end else begin
         bus.cal_done <= 1'b0;
         if (fail) begin
            state                <= IDLE;
            bus.busy             <= 1'b0;
            bus.cal_error        <= 1'b1;
            bus.err_code         <= fail_code;
            bus.offset_i_phase_a <= saved_a;
            bus.offset_i_phase_b <= saved_b;
            bus.offset_v         <= saved_v;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.cal_start) begin
                     state                <= SETTLE;
                     acc_a                <= '0;
                     acc_b                <= '0;
                     acc_v                <= '0;
                     smp_cnt              <= '0;
                     tmo_cnt              <= '0;
                     bus.cal_error        <= 1'b0;
                     bus.err_code         <= ERR_NONE;
                     bus.busy             <= 1'b1;
                     bus.offset_i_phase_a <= '0;
                     bus.offset_i_phase_b <= '0;
                     bus.offset_v         <= '0;
                  end else if (bus.wr_en) begin
                     case (bus.wr_sel)
                        2'd0: begin
                           saved_a              <= bus.wr_data;
                           bus.offset_i_phase_a <= bus.wr_data;
                        end
                        2'd1: begin
                           saved_b              <= bus.wr_data;
                           bus.offset_i_phase_b <= bus.wr_data;
                        end
                        2'd2: begin
                           saved_v              <= bus.wr_data;
                           bus.offset_v         <= bus.wr_data;
                        end
                        default: ;
                     endcase
                  end
               end
               SETTLE, ACCUM: begin
                  if (bus.sample_valid) begin
                     tmo_cnt <= '0;
                     if (state == SETTLE) begin
                        if (smp_cnt == SETTLE_LAST) begin
                           state   <= ACCUM;
                           smp_cnt <= '0;
                        end else begin
                           smp_cnt <= smp_cnt + CNT_W'(1);
                        end
                     end else begin
                        acc_a <= acc_a + ACC_W'(bus.sample_i_phase_a_16);
                        acc_b <= acc_b + ACC_W'(bus.sample_i_phase_b_16);
                        acc_v <= acc_v + ACC_W'(bus.sample_v_out_16);
                        if (smp_cnt == ACCUM_LAST) begin
                           state <= APPLY;
                        end else begin
                           smp_cnt <= smp_cnt + CNT_W'(1);
                        end
                     end
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
               APPLY: begin
                  state                <= IDLE;
                  bus.busy             <= 1'b0;
                  bus.cal_done         <= 1'b1;
                  saved_a              <= avg_a[15:0];
                  saved_b              <= avg_b[15:0];
                  saved_v              <= avg_v[15:0];
                  bus.offset_i_phase_a <= avg_a[15:0];
                  bus.offset_i_phase_b <= avg_b[15:0];
                  bus.offset_v         <= avg_v[15:0];
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_psg_ecfs_lvdcdc_sd_adc_offset_cal.sv
// Bench for the SD-ADC offset calibration sequencer: directed vectors, a per-cycle
// arithmetic model of the calibration outcome, and hand-computed literal expectations.
module tb_psg_ecfs_lvdcdc_sd_adc_offset_cal;
   localparam int AVG_LOG2 = 6;
   localparam int NAVG     = 64;
   localparam int SETTLE   = 4;
   localparam int TMO      = 1024;
   localparam int MAXO     = 2048;

   logic clk_adc;
   logic reset;
   psg_ecfs_lvdcdc_sd_adc_offset_cal_if bus ();

   psg_ecfs_lvdcdc_sd_adc_offset_cal #(
      .AVG_LOG2       (AVG_LOG2),
      .SETTLE_SAMPLES (SETTLE),
      .TIMEOUT_CYCLES (TMO),
      .MAX_OFFSET     (16'd2048)
   ) dut (
      .clk_adc (clk_adc),
      .reset   (reset),
      .bus     (bus.slave)
   );

   initial clk_adc = 1'b0;
   always #5 clk_adc = ~clk_adc;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: whether a calibration is running, strobes seen, idle run length, sums.
   bit          m_cal = 1'b0;
   int          m_strobes = 0;
   int          m_idle = 0;
   longint      m_sum [3];
   logic [15:0] m_saved [3];
   logic [15:0] exp_off [3];
   bit          exp_busy = 1'b0;
   bit          exp_done = 1'b0;
   bit          exp_err = 1'b0;
   logic [1:0]  exp_code = 2'd0;
   bit          live = 1'b0;

   function automatic longint avg_model(input longint s_in);
      longint s;
      s = s_in;
`ifdef PSG_ECFS_SD_ADC_CAL_ROUND_EN
      s = s + NAVG / 2;
`endif
      if (s >= 0) return s / NAVG;
      return -((-s + NAVG - 1) / NAVG);
   endfunction

   always @(posedge clk_adc) begin : model
      bit          cal;
      int          str;
      int          idl;
      longint      sum [3];
      logic [15:0] sv [3];
      bit          err;
      logic [1:0]  code;
      bit          done;
      bit          ok;
      longint      a [3];
      cal = m_cal; str = m_strobes; idl = m_idle; sum = m_sum; sv = m_saved;
      err = exp_err; code = exp_code; done = 1'b0;
      if (reset) begin
         cal = 1'b0; str = 0; idl = 0; sum = '{0, 0, 0}; sv = '{0, 0, 0};
         err = 1'b0; code = 2'd0;
      end else if (!cal) begin
         if (bus.cal_start) begin
            cal = 1'b1; str = 0; idl = 0; sum = '{0, 0, 0}; err = 1'b0; code = 2'd0;
         end else if (bus.wr_en && bus.wr_sel != 2'd3) begin
            sv[bus.wr_sel] = bus.wr_data;
         end
      end else if (bus.cal_abort) begin
         cal = 1'b0; err = 1'b1; code = 2'd3;
      end else if (str == SETTLE + NAVG) begin
         ok = 1'b1;
         for (int c = 0; c < 3; c++) begin
            a[c] = avg_model(sum[c]);
            if (a[c] > MAXO || a[c] < -MAXO) ok = 1'b0;
         end
         cal = 1'b0;
         if (ok) begin
            for (int c = 0; c < 3; c++) sv[c] = 16'(a[c]);
            done = 1'b1;
         end else begin
            err = 1'b1; code = 2'd2;
         end
      end else if (bus.sample_valid) begin
         if (str >= SETTLE) begin
            sum[0] = sum[0] + longint'(bus.sample_i_phase_a_16);
            sum[1] = sum[1] + longint'(bus.sample_i_phase_b_16);
            sum[2] = sum[2] + longint'(bus.sample_v_out_16);
         end
         str++;
         idl = 0;
      end else begin
         idl++;
         if (idl == TMO) begin
            cal = 1'b0; err = 1'b1; code = 2'd1;
         end
      end
      m_cal     <= cal;
      m_strobes <= str;
      m_idle    <= idl;
      m_sum     <= sum;
      m_saved   <= sv;
      for (int c = 0; c < 3; c++) exp_off[c] <= cal ? 16'd0 : sv[c];
      exp_busy  <= cal;
      exp_done  <= done;
      exp_err   <= err;
      exp_code  <= code;
      live      <= 1'b1;
   end

   always @(negedge clk_adc) begin
      if (live) begin
         check("cmp_offset_a", bus.offset_i_phase_a, exp_off[0]);
         check("cmp_offset_b", bus.offset_i_phase_b, exp_off[1]);
         check("cmp_offset_v", bus.offset_v, exp_off[2]);
         check("cmp_busy", 16'(bus.busy), 16'(exp_busy));
         check("cmp_cal_done", 16'(bus.cal_done), 16'(exp_done));
         check("cmp_cal_error", 16'(bus.cal_error), 16'(exp_err));
         check("cmp_err_code", 16'(bus.err_code), 16'(exp_code));
         if (bus.cal_done === 1'b1) done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_adc);
   endtask

   task automatic write_off(input logic [1:0] sel, input logic [15:0] data);
      bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
      tick(1);
      bus.wr_en = 1'b0;
   endtask

   task automatic start_cal();
      bus.cal_start = 1'b1;
      tick(1);
      bus.cal_start = 1'b0;
   endtask

   // n strobes, one every gap cycles; phase A alternates a0/a1 by strobe index.
   task automatic feed(input int n, input int gap, input int a0, input int a1,
                       input int b, input int v, input bit abort_last);
      for (int i = 0; i < n; i++) begin
         tick(gap - 1);
         bus.sample_i_phase_a_16 = 16'((i % 2 == 1) ? a1 : a0);
         bus.sample_i_phase_b_16 = 16'(b);
         bus.sample_v_out_16     = 16'(v);
         bus.sample_valid        = 1'b1;
         if (abort_last && i == n - 1) bus.cal_abort = 1'b1;
         tick(1);
         bus.sample_valid = 1'b0;
         bus.cal_abort    = 1'b0;
      end
   endtask

   task automatic wait_idle(input int max, output int cyc);
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < max) begin
         tick(1);
         cyc++;
      end
      check("wait_idle_bound", 16'(bus.busy), 16'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int done_snap;
      bus.cal_start = 1'b0; bus.cal_abort = 1'b0; bus.wr_en = 1'b0;
      bus.wr_sel = 2'd0; bus.wr_data = 16'd0; bus.sample_valid = 1'b0;
      bus.sample_i_phase_a_16 = '0; bus.sample_i_phase_b_16 = '0; bus.sample_v_out_16 = '0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("reset_offset_a", bus.offset_i_phase_a, 16'd0);
      check("reset_busy", 16'(bus.busy), 16'd0);
      check("reset_err_code", 16'(bus.err_code), 16'd0);

      // 1: manual write to phase B
      write_off(2'd1, 16'h0123);
      check("wr_offset_b", bus.offset_i_phase_b, 16'h0123);
      check("wr_offset_a", bus.offset_i_phase_a, 16'd0);
      check("wr_offset_v", bus.offset_v, 16'd0);

      // 2: constant samples, strobe every 128 cycles
      start_cal();
      check("cal2_busy", 16'(bus.busy), 16'd1);
      check("cal2_zero_b", bus.offset_i_phase_b, 16'd0);
      feed(SETTLE + NAVG, 128, 100, 100, -37, 512, 1'b0);
      wait_idle(5, cyc);
      check("cal2_apply_latency", 16'(cyc), 16'd1);
      check("cal2_done", 16'(bus.cal_done), 16'd1);
      check("cal2_offset_a", bus.offset_i_phase_a, 16'd100);
      check("cal2_offset_b", bus.offset_i_phase_b, 16'hFFDB);
      check("cal2_offset_v", bus.offset_v, 16'd512);

      // 3: alternating 3/4 on phase A
      start_cal();
      feed(SETTLE + NAVG, 2, 3, 4, 0, 0, 1'b0);
      wait_idle(5, cyc);
`ifdef PSG_ECFS_SD_ADC_CAL_ROUND_EN
      check("cal3_offset_a", bus.offset_i_phase_a, 16'd4);
`else
      check("cal3_offset_a", bus.offset_i_phase_a, 16'd3);
`endif

      // 4: range failure keeps prior offsets
      write_off(2'd0, 16'd10);
      write_off(2'd1, 16'd20);
      write_off(2'd2, 16'd30);
      done_snap = done_cnt;
      start_cal();
      feed(SETTLE + NAVG, 2, 0, 0, 0, 3000, 1'b0);
      wait_idle(5, cyc);
      check("cal4_err", 16'(bus.cal_error), 16'd1);
      check("cal4_code", 16'(bus.err_code), 16'd2);
      check("cal4_no_done", 16'(done_cnt - done_snap), 16'd0);
      check("cal4_offset_a", bus.offset_i_phase_a, 16'd10);
      check("cal4_offset_v", bus.offset_v, 16'd30);

      // 5: timeout after the 10th strobe, then restart clears the flag
      start_cal();
      check("cal5_err_cleared", 16'(bus.cal_error), 16'd0);
      feed(10, 2, 5, 5, 5, 5, 1'b0);
      wait_idle(TMO + 50, cyc);
      check("cal5_timeout_cycles", 16'(cyc), 16'(TMO));
      check("cal5_code", 16'(bus.err_code), 16'd1);
      check("cal5_offset_b", bus.offset_i_phase_b, 16'd20);
      bus.cal_start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = 16'h5555;
      tick(1);
      bus.cal_start = 1'b0; bus.wr_en = 1'b0;
      check("cal5_restart_err", 16'(bus.cal_error), 16'd0);
      check("cal5_restart_busy", 16'(bus.busy), 16'd1);
      bus.cal_abort = 1'b1;
      tick(1);
      bus.cal_abort = 1'b0;
      check("cal5_abort_code", 16'(bus.err_code), 16'd3);
      check("cal5_write_dropped", bus.offset_i_phase_a, 16'd10);

      // 6: abort on the final strobe, cal_start while busy ignored
      done_snap = done_cnt;
      start_cal();
      tick(3);
      start_cal();
      feed(SETTLE + NAVG, 2, 7, 7, 7, 7, 1'b1);
      check("cal6_busy", 16'(bus.busy), 16'd0);
      check("cal6_code", 16'(bus.err_code), 16'd3);
      check("cal6_no_done", 16'(done_cnt - done_snap), 16'd0);
      check("cal6_offset_a", bus.offset_i_phase_a, 16'd10);
      check("cal6_offset_b", bus.offset_i_phase_b, 16'd20);
      tick(2);

      // reset in the middle of a calibration
      start_cal();
      feed(6, 2, 9, 9, 9, 9, 1'b0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("midreset_offset_v", bus.offset_v, 16'd0);
      check("midreset_busy", 16'(bus.busy), 16'd0);
      check("midreset_err", 16'(bus.cal_error), 16'd0);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
